// File: rtl/axi_arb_pkg.sv
// Shared types for the two-master AXI arbiter.
// - rd_state_e / wr_state_e : read and write channel FSM states
// - mst_idx_t               : master index (0 = M0 instruction fetch, 1 = M1 data)
// - NUM_MST                 : number of arbitrated masters
// - idx2onehot              : master index -> one-hot grant vector
package axi_arb_pkg;

  localparam int NUM_MST = 2;

  typedef logic mst_idx_t;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_ADDR,
    RD_DATA
  } rd_state_e;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_ADDR,
    WR_DATA,
    WR_RESP
  } wr_state_e;

  function automatic logic [NUM_MST-1:0] idx2onehot(input mst_idx_t idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick, purely combinational.
// - req     in  : request vector, bit i = master i requesting
// - prio    in  : master favoured when both request (the one not served last)
// - gnt     out : one-hot grant, zero when nobody requests
// - gnt_idx out : index of the winning master (meaningful only when req != 0)
module rr_arb2
  import axi_arb_pkg::*;
(
  input  logic [NUM_MST-1:0] req,
  input  mst_idx_t           prio,
  output logic [NUM_MST-1:0] gnt,
  output mst_idx_t           gnt_idx
);

  // NOTE: every output gets a default before any branch, so no latch is inferred.
  always_comb begin
    gnt_idx = prio;
    if (req == 2'b01) begin
      gnt_idx = 1'b0;
    end else if (req == 2'b10) begin
      gnt_idx = 1'b1;
    end
    gnt = (req != '0) ? idx2onehot(gnt_idx) : '0;
  end

endmodule

// File: rtl/axi_master_arbiter.sv
// Grant/phase controller sharing one AXI bridge between M0 (fetch) and M1 (data).
// Read and write sides each run an independent FSM with a round-robin pointer
// and a watchdog that force-releases a stuck data/response phase.
// Ports:
// - ACLK, ARESETn               : clock, asynchronous active-low reset
// - ar_req, ar_ready, r_done    : read requests, AR handshake, last R beat
// - aw_req, aw_ready, w_done,
//   b_done                      : write requests, AW handshake, last W beat, B handshake
// - ar_gnt, ar_phase, r_sel     : read grant, AR-routing enable, R owner
// - aw_gnt, aw_phase, w_phase,
//   b_sel                       : write grant, AW/W routing enables, W/B owner
// - rd_timeout, wr_timeout      : one-cycle pulse on watchdog release
module axi_master_arbiter
  import axi_arb_pkg::*;
#(
  parameter int TIMEOUT = 1023,
  parameter int CNT_W   = 10
) (
  input  logic               ACLK,
  input  logic               ARESETn,
  input  logic [NUM_MST-1:0] ar_req,
  input  logic               ar_ready,
  input  logic               r_done,
  input  logic [NUM_MST-1:0] aw_req,
  input  logic               aw_ready,
  input  logic               w_done,
  input  logic               b_done,
  output logic [NUM_MST-1:0] ar_gnt,
  output logic               ar_phase,
  output logic               r_sel,
  output logic [NUM_MST-1:0] aw_gnt,
  output logic               aw_phase,
  output logic               w_phase,
  output logic               b_sel,
  output logic               rd_timeout,
  output logic               wr_timeout
);

  localparam bit             WD_EN   = (TIMEOUT > 0);
  // The phase has then lasted TIMEOUT cycles including the current one.
  localparam logic [CNT_W-1:0] TO_LAST = WD_EN ? CNT_W'(TIMEOUT - 1) : '0;

  rd_state_e          rd_state_q, rd_state_d;
  wr_state_e          wr_state_q, wr_state_d;
  logic [NUM_MST-1:0] ar_gnt_q, ar_gnt_d, aw_gnt_q, aw_gnt_d;
  mst_idx_t           r_sel_q, r_sel_d, b_sel_q, b_sel_d;
  mst_idx_t           rd_prio_q, rd_prio_d, wr_prio_q, wr_prio_d;
  logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic               rd_timeout_q, rd_timeout_d, wr_timeout_q, wr_timeout_d;

  logic [NUM_MST-1:0] rd_pick_gnt, wr_pick_gnt;
  mst_idx_t           rd_pick_idx, wr_pick_idx;
  logic               rd_expired, wr_expired;

  rr_arb2 u_rd_arb (.req(ar_req), .prio(rd_prio_q), .gnt(rd_pick_gnt), .gnt_idx(rd_pick_idx));
  rr_arb2 u_wr_arb (.req(aw_req), .prio(wr_prio_q), .gnt(wr_pick_gnt), .gnt_idx(wr_pick_idx));

  assign rd_expired = WD_EN && (rd_cnt_q == TO_LAST);
  assign wr_expired = WD_EN && (wr_cnt_q == TO_LAST);

  // Read side. A done in the expiry cycle wins, so no timeout pulse then.
  always_comb begin
    rd_state_d   = rd_state_q;
    ar_gnt_d     = ar_gnt_q;
    r_sel_d      = r_sel_q;
    rd_prio_d    = rd_prio_q;
    rd_cnt_d     = rd_cnt_q;
    rd_timeout_d = 1'b0;
    case (rd_state_q)
      RD_IDLE: if (ar_req != '0) begin
        rd_state_d = RD_ADDR;
        ar_gnt_d   = rd_pick_gnt;
        r_sel_d    = rd_pick_idx;
      end
      RD_ADDR: if (ar_ready) begin
        rd_state_d = RD_DATA;
        rd_cnt_d   = '0;
      end
      RD_DATA: begin
        if (r_done || rd_expired) begin
          rd_state_d   = RD_IDLE;
          ar_gnt_d     = '0;
          r_sel_d      = 1'b0;
          rd_prio_d    = ~r_sel_q;
          rd_cnt_d     = '0;
          rd_timeout_d = ~r_done;
        end else if (WD_EN) begin
          rd_cnt_d = rd_cnt_q + CNT_W'(1);
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  // Write side. The counter restarts when moving from W data to B response.
  always_comb begin
    logic release_wr, phase_done;
    wr_state_d   = wr_state_q;
    aw_gnt_d     = aw_gnt_q;
    b_sel_d      = b_sel_q;
    wr_prio_d    = wr_prio_q;
    wr_cnt_d     = wr_cnt_q;
    wr_timeout_d = 1'b0;
    release_wr   = 1'b0;
    phase_done   = 1'b0;
    case (wr_state_q)
      WR_IDLE: if (aw_req != '0) begin
        wr_state_d = WR_ADDR;
        aw_gnt_d   = wr_pick_gnt;
        b_sel_d    = wr_pick_idx;
      end
      WR_ADDR: if (aw_ready) begin
        wr_state_d = WR_DATA;
        wr_cnt_d   = '0;
      end
      WR_DATA: begin
        if (w_done) begin
          wr_state_d = WR_RESP;
          wr_cnt_d   = '0;
        end else if (wr_expired) begin
          release_wr = 1'b1;
        end else if (WD_EN) begin
          wr_cnt_d = wr_cnt_q + CNT_W'(1);
        end
      end
      WR_RESP: begin
        if (b_done || wr_expired) begin
          release_wr = 1'b1;
          phase_done = b_done;
        end else if (WD_EN) begin
          wr_cnt_d = wr_cnt_q + CNT_W'(1);
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase
    if (release_wr) begin
      wr_state_d   = WR_IDLE;
      aw_gnt_d     = '0;
      b_sel_d      = 1'b0;
      wr_prio_d    = ~b_sel_q;
      wr_cnt_d     = '0;
      wr_timeout_d = ~phase_done;
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rd_state_q   <= RD_IDLE;
      wr_state_q   <= WR_IDLE;
      ar_gnt_q     <= '0;
      aw_gnt_q     <= '0;
      r_sel_q      <= 1'b0;
      b_sel_q      <= 1'b0;
      rd_prio_q    <= 1'b0;
      wr_prio_q    <= 1'b0;
      rd_cnt_q     <= '0;
      wr_cnt_q     <= '0;
      rd_timeout_q <= 1'b0;
      wr_timeout_q <= 1'b0;
    end else begin
      rd_state_q   <= rd_state_d;
      wr_state_q   <= wr_state_d;
      ar_gnt_q     <= ar_gnt_d;
      aw_gnt_q     <= aw_gnt_d;
      r_sel_q      <= r_sel_d;
      b_sel_q      <= b_sel_d;
      rd_prio_q    <= rd_prio_d;
      wr_prio_q    <= wr_prio_d;
      rd_cnt_q     <= rd_cnt_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_timeout_q <= rd_timeout_d;
      wr_timeout_q <= wr_timeout_d;
    end
  end

  assign ar_gnt     = ar_gnt_q;
  assign r_sel      = r_sel_q;
  assign ar_phase   = (rd_state_q == RD_ADDR);
  assign aw_gnt     = aw_gnt_q;
  assign b_sel      = b_sel_q;
  assign aw_phase   = (wr_state_q == WR_ADDR);
  assign w_phase    = (wr_state_q == WR_DATA);
  assign rd_timeout = rd_timeout_q;
  assign wr_timeout = wr_timeout_q;

endmodule

// File: tb/tb_axi_master_arbiter.sv
// Self-checking bench for axi_master_arbiter: directed scenarios followed by
// randomized traffic, all compared against a transaction-level model.
module tb_axi_master_arbiter;

  localparam int TO = 8;

  logic       ACLK = 1'b0;
  logic       ARESETn = 1'b0;
  logic [1:0] ar_req = '0, aw_req = '0;
  logic       ar_ready = 1'b0, r_done = 1'b0;
  logic       aw_ready = 1'b0, w_done = 1'b0, b_done = 1'b0;
  logic [1:0] ar_gnt, aw_gnt;
  logic       ar_phase, r_sel, aw_phase, w_phase, b_sel, rd_timeout, wr_timeout;

  always #5 ACLK = ~ACLK;

  axi_master_arbiter #(.TIMEOUT(TO), .CNT_W(4)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .ar_req(ar_req), .ar_ready(ar_ready), .r_done(r_done),
    .aw_req(aw_req), .aw_ready(aw_ready), .w_done(w_done), .b_done(b_done),
    .ar_gnt(ar_gnt), .ar_phase(ar_phase), .r_sel(r_sel),
    .aw_gnt(aw_gnt), .aw_phase(aw_phase), .w_phase(w_phase), .b_sel(b_sel),
    .rd_timeout(rd_timeout), .wr_timeout(wr_timeout)
  );

  logic [10:0] dut_vec;
  assign dut_vec = {ar_gnt, ar_phase, r_sel, aw_gnt, aw_phase, w_phase, b_sel,
                    rd_timeout, wr_timeout};

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transaction-level model. Phase: read 0 idle / 1 address / 2 data;
  // write 0 idle / 1 address / 2 data / 3 response. age = cycles spent in the phase.
  int rd_ph, rd_own, rd_age, rd_fav;
  int wr_ph, wr_own, wr_age, wr_fav;
  bit rd_to, wr_to;

  function automatic int pick(input logic [1:0] req, input int fav);
    if (req == 2'b11) return fav;
    return req[1] ? 1 : 0;
  endfunction

  task automatic model_reset();
    rd_ph = 0; rd_own = 0; rd_age = 0; rd_fav = 0; rd_to = 1'b0;
    wr_ph = 0; wr_own = 0; wr_age = 0; wr_fav = 0; wr_to = 1'b0;
  endtask

  task automatic model_clock();
    rd_to = 1'b0;
    if (rd_ph == 0) begin
      if (ar_req != 2'b00) begin rd_own = pick(ar_req, rd_fav); rd_ph = 1; end
    end else if (rd_ph == 1) begin
      if (ar_ready) begin rd_ph = 2; rd_age = 0; end
    end else begin
      rd_age++;
      if (r_done || rd_age == TO) begin
        rd_to = !r_done; rd_ph = 0; rd_fav = 1 - rd_own;
      end
    end

    wr_to = 1'b0;
    if (wr_ph == 0) begin
      if (aw_req != 2'b00) begin wr_own = pick(aw_req, wr_fav); wr_ph = 1; end
    end else if (wr_ph == 1) begin
      if (aw_ready) begin wr_ph = 2; wr_age = 0; end
    end else if (wr_ph == 2) begin
      wr_age++;
      if (w_done) begin wr_ph = 3; wr_age = 0; end
      else if (wr_age == TO) begin wr_to = 1'b1; wr_ph = 0; wr_fav = 1 - wr_own; end
    end else begin
      wr_age++;
      if (b_done || wr_age == TO) begin
        wr_to = !b_done; wr_ph = 0; wr_fav = 1 - wr_own;
      end
    end
  endtask

  function automatic logic [10:0] model_out();
    logic [1:0] ag, wg;
    ag = (rd_ph != 0) ? ((rd_own == 1) ? 2'b10 : 2'b01) : 2'b00;
    wg = (wr_ph != 0) ? ((wr_own == 1) ? 2'b10 : 2'b01) : 2'b00;
    return {ag, rd_ph == 1, rd_ph != 0 && rd_own == 1,
            wg, wr_ph == 1, wr_ph == 2, wr_ph != 0 && wr_own == 1, rd_to, wr_to};
  endfunction

  task automatic drive(input logic [1:0] ar, input logic ard, input logic rd,
                       input logic [1:0] aw, input logic awr, input logic wd,
                       input logic bd);
    ar_req = ar; ar_ready = ard; r_done = rd;
    aw_req = aw; aw_ready = awr; w_done = wd; b_done = bd;
  endtask

  // One clock: advance the model on the pre-edge inputs, then compare after the edge.
  task automatic step(input string tag);
    model_clock();
    @(posedge ACLK);
    #1;
    check(tag, 32'(dut_vec), 32'(model_out()));
  endtask

  initial begin
    int lat;
    model_reset();
    #12;
    check("reset_outputs", 32'(dut_vec), 32'(0));
    @(negedge ACLK);
    ARESETn = 1'b1;

    // Both request after reset: M0 first, then M1 on the next round.
    drive(2'b11, 0, 0, 2'b00, 0, 0, 0); step("rr_first");
    check("rr_first_gnt", 32'(ar_gnt), 32'(2'b01));
    check("rr_first_phase", 32'(ar_phase), 32'(1));
    drive(2'b00, 1, 0, 2'b00, 0, 0, 0); step("rr_addr");
    drive(2'b00, 0, 1, 2'b00, 0, 0, 0); step("rr_done");
    drive(2'b11, 0, 0, 2'b00, 0, 0, 0); step("rr_second");
    check("rr_second_gnt", 32'(ar_gnt), 32'(2'b10));
    drive(2'b00, 1, 0, 2'b00, 0, 0, 0); step("rr2_addr");
    drive(2'b00, 0, 1, 2'b00, 0, 0, 0); step("rr2_done");

    // Long AR stall: no watchdog in the address phase.
    drive(2'b01, 0, 0, 2'b00, 0, 0, 0);
    for (int i = 0; i < 51; i++) step("ar_stall");
    check("ar_stall_gnt", 32'(ar_gnt), 32'(2'b01));
    check("ar_stall_phase", 32'(ar_phase), 32'(1));
    drive(2'b00, 1, 0, 2'b00, 0, 0, 0); step("ar_stall_hs");
    drive(2'b00, 0, 1, 2'b00, 0, 0, 0); step("ar_stall_done");

    // Write by M1 through all phases.
    drive(2'b00, 0, 0, 2'b10, 0, 0, 0); step("wr_grant");
    check("wr_grant_gnt", 32'(aw_gnt), 32'(2'b10));
    check("wr_addr_wphase", 32'(w_phase), 32'(0));
    drive(2'b00, 0, 0, 2'b00, 1, 0, 0); step("wr_aw_hs");
    drive(2'b00, 0, 0, 2'b00, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step("wr_data_wait");
      check("wr_data_wphase", 32'(w_phase), 32'(1));
      check("wr_data_bsel", 32'(b_sel), 32'(1));
    end
    drive(2'b00, 0, 0, 2'b00, 0, 1, 0); step("wr_wlast");
    check("wr_resp_wphase", 32'(w_phase), 32'(0));
    check("wr_resp_bsel", 32'(b_sel), 32'(1));
    drive(2'b00, 0, 0, 2'b00, 0, 0, 1); step("wr_bresp");
    check("wr_release_gnt", 32'(aw_gnt), 32'(2'b00));

    // Read watchdog: pulse TO cycles after entering the data phase.
    drive(2'b01, 0, 0, 2'b00, 0, 0, 0); step("to_grant");
    drive(2'b00, 1, 0, 2'b00, 0, 0, 0); step("to_hs");
    drive(2'b00, 0, 0, 2'b00, 0, 0, 0);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      step("to_wait");
      if (rd_timeout === 1'b1) begin lat = i; break; end
    end
    check("to_latency", 32'(lat), 32'(TO));
    drive(2'b11, 0, 0, 2'b00, 0, 0, 0); step("to_regrant");
    check("to_ptr_moved", 32'(ar_gnt), 32'(2'b10));
    drive(2'b00, 1, 0, 2'b00, 0, 0, 0); step("to2_hs");
    drive(2'b00, 0, 1, 2'b00, 0, 0, 0); step("to2_done");

    // Concurrent read by M0 and write by M1.
    drive(2'b01, 0, 0, 2'b10, 0, 0, 0); step("cc_grant");
    check("cc_grants", 32'({ar_gnt, aw_gnt}), 32'(4'b0110));
    drive(2'b00, 1, 0, 2'b00, 1, 0, 0); step("cc_hs");
    drive(2'b00, 0, 0, 2'b00, 0, 1, 0); step("cc_wlast");
    drive(2'b00, 0, 1, 2'b00, 0, 0, 1); step("cc_done");

    // Asynchronous reset in the middle of a read data phase.
    drive(2'b10, 0, 0, 2'b00, 0, 0, 0); step("rst_grant");
    drive(2'b00, 1, 0, 2'b00, 0, 0, 0); step("rst_hs");
    drive(2'b00, 0, 0, 2'b00, 0, 0, 0);
    #2 ARESETn = 1'b0;
    #1;
    check("rst_async_gnt", 32'(ar_gnt), 32'(2'b00));
    check("rst_async_rsel", 32'(r_sel), 32'(0));
    model_reset();
    @(negedge ACLK);
    ARESETn = 1'b1;
    drive(2'b11, 0, 0, 2'b00, 0, 0, 0); step("rst_regrant");
    check("rst_ptr_m0", 32'(ar_gnt), 32'(2'b01));
    drive(2'b00, 1, 0, 2'b00, 0, 0, 0); step("rst2_hs");
    drive(2'b00, 0, 1, 2'b00, 0, 0, 0); step("rst2_done");

    // Randomized traffic; done strobes kept sparse so watchdog releases also occur.
    for (int i = 0; i < 3000; i++) begin
      drive(2'($urandom_range(3)), 1'($urandom_range(1)), $urandom_range(99) < 15,
            2'($urandom_range(3)), 1'($urandom_range(1)), $urandom_range(99) < 20,
            $urandom_range(99) < 15);
      step("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
